// File: rtl/npu_pkg.sv
// rtl/npu_pkg.sv - shared states and NPU register map for the conv feeder
package npu_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_RD,
    S_WR,
    S_TRIG,
    S_WAIT,
    S_DONE
  } state_t;

  localparam logic [15:0] NPU_ADDR_IMG  = 16'h1000;
  localparam logic [15:0] NPU_ADDR_CTRL = 16'h4000;
  localparam logic [31:0] CTRL_TRIG     = 32'h0000_0001;
  localparam logic [31:0] CTRL_IMG_CLR  = 32'h0000_0008;

  localparam int RD_CYCLES   = 4;
  localparam int WAIT_CYCLES = 2;

endpackage

// File: rtl/npu_conv_feeder.sv
// rtl/npu_conv_feeder.sv - streams image columns from pixel memory into the NPU window
// Outputs are registered from next-state values, so a write shows during its own state cycle.
module npu_conv_feeder
  import npu_pkg::*;
#(
  parameter int IN_H   = 16,
  parameter int IN_W   = 15,
  parameter int K_H    = 3,
  parameter int K_W    = 3,
  parameter int MEM_AW = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              mem_rd,
  output logic [MEM_AW-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic              npu_ena,
  output logic              npu_wea,
  output logic [15:0]       npu_addra,
  output logic [31:0]       npu_dina
);

  localparam logic [7:0] ROW_LAST = 8'(IN_H - K_H);
  localparam logic [7:0] COL_END  = 8'(IN_W);
  localparam logic [2:0] RD_LAST  = 3'(RD_CYCLES - 1);
  localparam logic [2:0] KH_N     = 3'(K_H);
  localparam logic [2:0] KW_N     = 3'(K_W);
  localparam logic [1:0] WAIT_LAST = 2'(WAIT_CYCLES - 1);

  state_t              state_q, state_d;
  logic [7:0]          r_q, r_d;
  logic [7:0]          c_q, c_d;
  logic [2:0]          rd_cnt_q, rd_cnt_d;
  logic [2:0]          n_q, n_d;
  logic [1:0]          wait_cnt_q, wait_cnt_d;
  logic [8*K_H-1:0]    lanes_q, lanes_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                mem_rd_q, mem_rd_d;
  logic [MEM_AW-1:0]   mem_addr_q, mem_addr_d;
  logic                npu_ena_q, npu_ena_d;
  logic [15:0]         npu_addra_q, npu_addra_d;
  logic [31:0]         npu_dina_q, npu_dina_d;
  logic [2:0]          n_inc;

  always_comb begin
    state_d    = state_q;
    r_d        = r_q;
    c_d        = c_q;
    rd_cnt_d   = rd_cnt_q;
    n_d        = n_q;
    wait_cnt_d = wait_cnt_q;
    lanes_d    = lanes_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    n_inc      = (n_q < KW_N) ? n_q + 3'd1 : n_q;

    // Pixel read on rd_cnt k returns during rd_cnt k+1 and lands in lane k.
    for (int i = 0; i < K_H; i++) begin
      if (state_q == S_RD && rd_cnt_q == 3'(i + 1)) begin
        lanes_d[8*i +: 8] = mem_rdata;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (start && !done_q) begin
          r_d     = 8'd0;
          c_d     = 8'd0;
          busy_d  = 1'b1;
          state_d = S_CLR;
        end
      end
      S_CLR: begin
        n_d      = 3'd0;
        rd_cnt_d = 3'd0;
        state_d  = S_RD;
      end
      S_RD: begin
        if (rd_cnt_q == RD_LAST) begin
          state_d = S_WR;
        end else begin
          rd_cnt_d = rd_cnt_q + 3'd1;
        end
      end
      S_WR: begin
        c_d = c_q + 8'd1;
        n_d = n_inc;
        if (n_inc < KW_N) begin
          rd_cnt_d = 3'd0;
          state_d  = S_RD;
        end else begin
          state_d = S_TRIG;
        end
      end
      S_TRIG: begin
        wait_cnt_d = 2'd0;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        if (wait_cnt_q == WAIT_LAST) begin
          if (c_q < COL_END) begin
            rd_cnt_d = 3'd0;
            state_d  = S_RD;
          end else if (r_q < ROW_LAST) begin
            r_d     = r_q + 8'd1;
            c_d     = 8'd0;
            state_d = S_CLR;
          end else begin
            state_d = S_DONE;
          end
        end else begin
          wait_cnt_d = wait_cnt_q + 2'd1;
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mem_rd_d    = (state_d == S_RD) && (rd_cnt_d < KH_N);
    mem_addr_d  = '0;
    npu_ena_d   = 1'b0;
    npu_addra_d = 16'h0000;
    npu_dina_d  = 32'h0000_0000;

    if (mem_rd_d) begin
      mem_addr_d = MEM_AW'((32'(r_d) + 32'(rd_cnt_d)) * 32'(IN_W) + 32'(c_d));
    end

    case (state_d)
      S_CLR: begin
        npu_ena_d   = 1'b1;
        npu_addra_d = NPU_ADDR_CTRL;
        npu_dina_d  = CTRL_IMG_CLR;
      end
      S_WR: begin
        npu_ena_d   = 1'b1;
        npu_addra_d = NPU_ADDR_IMG;
        npu_dina_d  = 32'(lanes_d);
      end
      S_TRIG: begin
        npu_ena_d   = 1'b1;
        npu_addra_d = NPU_ADDR_CTRL;
        npu_dina_d  = CTRL_TRIG;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      r_q         <= 8'd0;
      c_q         <= 8'd0;
      rd_cnt_q    <= 3'd0;
      n_q         <= 3'd0;
      wait_cnt_q  <= 2'd0;
      lanes_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      mem_rd_q    <= 1'b0;
      mem_addr_q  <= '0;
      npu_ena_q   <= 1'b0;
      npu_addra_q <= 16'h0000;
      npu_dina_q  <= 32'h0000_0000;
    end else begin
      state_q     <= state_d;
      r_q         <= r_d;
      c_q         <= c_d;
      rd_cnt_q    <= rd_cnt_d;
      n_q         <= n_d;
      wait_cnt_q  <= wait_cnt_d;
      lanes_q     <= lanes_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      mem_rd_q    <= mem_rd_d;
      mem_addr_q  <= mem_addr_d;
      npu_ena_q   <= npu_ena_d;
      npu_addra_q <= npu_addra_d;
      npu_dina_q  <= npu_dina_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign mem_rd    = mem_rd_q;
  assign mem_addr  = mem_addr_q;
  assign npu_ena   = npu_ena_q;
  assign npu_wea   = npu_ena_q;
  assign npu_addra = npu_addra_q;
  assign npu_dina  = npu_dina_q;

endmodule

// File: tb/tb_npu_conv_feeder.sv
// tb/tb_npu_conv_feeder.sv - directed bench for npu_conv_feeder on a ramp image memory
module tb_npu_conv_feeder;
  import npu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        busy, done, mem_rd, npu_ena, npu_wea;
  logic [7:0]  mem_addr;
  logic [7:0]  mem_rdata = 8'h00;
  logic [15:0] npu_addra;
  logic [31:0] npu_dina;

  npu_conv_feeder dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .npu_ena(npu_ena), .npu_wea(npu_wea), .npu_addra(npu_addra), .npu_dina(npu_dina)
  );

  always #5 clk = ~clk;

  // Ramp memory: pixel value equals its address, one cycle read latency.
  always @(posedge clk) if (mem_rd) mem_rdata <= mem_addr;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [47:0] wr_log [0:4095];
  int wr_n = 0, trig_cnt = 0, clr_cnt = 0, img_cnt = 0, done_cnt = 0;
  int wea_err = 0, gap_err = 0, since = 8;
  logic [7:0]  rd0 = 0, rd1 = 0, rd2 = 0;
  logic [31:0] last_img = 0;
  wire is_trig = npu_ena && npu_addra == 16'h4000 && npu_dina == 32'h1;
  wire bus_act = npu_ena || mem_rd;

  always @(negedge clk) begin
    if (npu_ena !== npu_wea) wea_err <= wea_err + 1;
    if (npu_ena) begin
      if (wr_n < 4096) wr_log[wr_n] <= {npu_addra, npu_dina};
      wr_n <= wr_n + 1;
      if (npu_addra == 16'h4000 && npu_dina == 32'h8) clr_cnt <= clr_cnt + 1;
      if (npu_addra == 16'h1000) begin
        img_cnt  <= img_cnt + 1;
        last_img <= npu_dina;
      end
    end
    if (is_trig) begin
      trig_cnt <= trig_cnt + 1;
      since    <= 0;
    end else if (since < 8) begin
      since <= since + 1;
    end
    if (!is_trig && (since == 0 || since == 1) && bus_act) gap_err <= gap_err + 1;
    if (!is_trig && since == 2 && !bus_act && (trig_cnt % 182) != 0) gap_err <= gap_err + 1;
    if (mem_rd) begin
      rd2 <= rd1;
      rd1 <= rd0;
      rd0 <= mem_addr;
    end
    if (done) done_cnt <= done_cnt + 1;
  end

  int n_checks = 0, n_errors = 0;

  task automatic check(input string tag, input logic [47:0] got, input logic [47:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_quiet(input string pfx);
    check({pfx, "_busy"},   48'(busy),      48'd0);
    check({pfx, "_done"},   48'(done),      48'd0);
    check({pfx, "_mem_rd"}, 48'(mem_rd),    48'd0);
    check({pfx, "_addr"},   48'(mem_addr),  48'd0);
    check({pfx, "_ena"},    48'(npu_ena),   48'd0);
    check({pfx, "_wea"},    48'(npu_wea),   48'd0);
    check({pfx, "_addra"},  48'(npu_addra), 48'd0);
    check({pfx, "_dina"},   48'(npu_dina),  48'd0);
    check({pfx, "_state"},  48'(dut.state_q), 48'(S_IDLE));
  endtask

  task automatic pulse_start(output int s);
    @(negedge clk);
    start = 1'b1;
    s = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output bit seen, output int dcyc);
    seen = 0;
    dcyc = 0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (done) begin
        seen = 1;
        dcyc = cyc;
        break;
      end
    end
  endtask

  int s, dcyc, base, t0, c0, i0, d0, w0;
  bit seen;

  initial begin
    rst = 1'b1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_quiet("reset");
    rst = 1'b0;

    // Pass 1: undisturbed full pass.
    @(negedge clk);
    base = wr_n; t0 = trig_cnt; c0 = clr_cnt; i0 = img_cnt; d0 = done_cnt;
    pulse_start(s);
    check("busy_after_start", 48'(busy), 48'd1);
    wait_done(seen, dcyc);
    check("p1_done_seen", 48'(seen), 48'd1);
    check("p1_done_latency", 48'(dcyc - s), 48'd1612);
    check("p1_busy_at_done", 48'(busy), 48'd0);
    check("p1_w0_clr",  wr_log[base],     {16'h4000, 32'h0000_0008});
    check("p1_w1_col0", wr_log[base + 1], {16'h1000, 32'h001E_0F00});
    check("p1_w2_col1", wr_log[base + 2], {16'h1000, 32'h001F_1001});
    check("p1_w3_col2", wr_log[base + 3], {16'h1000, 32'h0020_1102});
    check("p1_w4_trig", wr_log[base + 4], {16'h4000, 32'h0000_0001});
    check("p1_w5_col3", wr_log[base + 5], {16'h1000, 32'h0021_1203});
    @(negedge clk);
    check("p1_trig_count", 48'(trig_cnt - t0), 48'd182);
    check("p1_clr_count",  48'(clr_cnt - c0),  48'd14);
    check("p1_img_count",  48'(img_cnt - i0),  48'd210);
    check("p1_done_pulses", 48'(done_cnt - d0), 48'd1);
    check("p1_gap_err", 48'(gap_err), 48'd0);
    check("p1_wea_err", 48'(wea_err), 48'd0);
    check("p1_last_rd_a", 48'(rd2), 48'd209);
    check("p1_last_rd_b", 48'(rd1), 48'd224);
    check("p1_last_rd_c", 48'(rd0), 48'd239);
    check("p1_last_img", 48'(last_img), 48'h00EF_E0D1);

    // Pass 2: extra start at cycle 50, then a start coinciding with done.
    repeat (3) @(negedge clk);
    t0 = trig_cnt; d0 = done_cnt;
    pulse_start(s);
    while (cyc < s + 50) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(seen, dcyc);
    start = 1'b1;
    check("p2_done_seen", 48'(seen), 48'd1);
    check("p2_done_latency", 48'(dcyc - s), 48'd1612);
    @(negedge clk);
    start = 1'b0;
    w0 = wr_n;
    check("p2_trig_count", 48'(trig_cnt - t0), 48'd182);
    check("p2_busy_after_done_start", 48'(busy), 48'd0);
    repeat (5) @(negedge clk);
    check("p2_no_writes_after", 48'(wr_n - w0), 48'd0);
    check("p2_done_pulses", 48'(done_cnt - d0), 48'd1);
    check("p2_gap_err", 48'(gap_err), 48'd0);

    // Pass 3: reset while a column write is on the bus.
    pulse_start(s);
    seen = 0;
    for (int k = 0; k < 50; k++) begin
      if (npu_ena && npu_addra == 16'h1000) begin
        seen = 1;
        break;
      end
      @(negedge clk);
    end
    check("p3_wr_seen", 48'(seen), 48'd1);
    rst = 1'b1;
    @(negedge clk);
    check_quiet("p3_abort");
    rst = 1'b0;
    w0 = wr_n; d0 = done_cnt;
    repeat (20) @(negedge clk);
    check("p3_no_writes", 48'(wr_n - w0), 48'd0);
    check("p3_no_done",   48'(done_cnt - d0), 48'd0);
    base = wr_n;
    pulse_start(s);
    repeat (12) @(negedge clk);
    check("p3_fresh_clr",  wr_log[base],     {16'h4000, 32'h0000_0008});
    check("p3_fresh_col0", wr_log[base + 1], {16'h1000, 32'h001E_0F00});
    rst = 1'b1;
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
